spi_xfer_seq: RTL and testbench
===============================

SPI_XFER_SEQ -- requirements
Module: spi_xfer_seq

Interface
REQ-001 SHALL have parameter CS_WIDTH, default 4, number of slave-select lines.
REQ-002 SHALL have parameter LEN_WIDTH, default 16, width of the word-count field.
REQ-003 SHALL have parameter DLY_WIDTH, default 8, width of the setup/hold delay fields.
REQ-004 clk_i  in  1  single clock; all logic on rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 en_i  in  1  controller enable; low aborts and holds IDLE.
REQ-007 start_i  in  1  one-cycle request to begin a transfer.
REQ-008 ass_i  in  1  1 = auto slave select, 0 = manual (nss_o follows ~sel_i).
REQ-009 sel_i  in  CS_WIDTH  slave-select mask, 1 = selected.
REQ-010 len_i  in  LEN_WIDTH  words to transfer; sampled at start.
REQ-011 setup_i / hold_i  in  DLY_WIDTH each  clk cycles nss-to-first-word / last-word-to-nss-release; sampled at start.
REQ-012 tx_valid_i  in  1  TX FIFO non-empty; tx_pop_o  out  1  TX FIFO pop strobe.
REQ-013 rx_ready_i  in  1  RX FIFO non-full; rx_push_o  out  1  RX FIFO push strobe.
REQ-014 core_st_o  out  1  one-cycle word-start to shift core; core_done_i  in  1  one-cycle word-complete from core.
REQ-015 nss_o  out  CS_WIDTH  active-low slave selects; busy_o  out  1  not IDLE; done_o  out  1  one-cycle transfer-complete pulse.

Function
REQ-016 States SHALL be IDLE, SETUP, WAIT_TX, XFER, WAIT_RX, HOLD.
REQ-017 IDLE: start_i & en_i & len_i!=0 SHALL latch len/setup/hold/sel and enter SETUP next cycle; start_i with len_i==0 SHALL pulse done_o next cycle and stay IDLE.
REQ-018 start_i outside IDLE SHALL be ignored.
REQ-019 SETUP SHALL last exactly setup_i cycles (0 = 1 cycle minimum), then WAIT_TX.
REQ-020 WAIT_TX: when tx_valid_i=1, tx_pop_o and core_st_o SHALL assert together for one cycle and state SHALL enter XFER; otherwise wait indefinitely (stall, no SCK).
REQ-021 XFER: on core_done_i with rx_ready_i=1, rx_push_o SHALL assert same cycle and remaining count decrement; with rx_ready_i=0 enter WAIT_RX.
REQ-022 WAIT_RX: rx_push_o SHALL assert in first cycle rx_ready_i=1, then decrement.
REQ-023 After decrement: remaining==0 -> HOLD, else WAIT_TX; next core_st_o no earlier than 1 cycle after push.
REQ-024 HOLD SHALL last hold_i cycles (0 = 1 cycle), then IDLE with done_o pulsed in the IDLE-entry cycle.
REQ-025 Auto mode: nss_o = ~sel latched for SETUP..HOLD, all-ones in IDLE; manual mode: nss_o = ~sel_i combinationally-registered every cycle regardless of state.
REQ-026 en_i low in any state SHALL return to IDLE next cycle, release nss_o (auto), suppress done_o, clear counters; no strobe issued that cycle.
REQ-027 core_done_i outside XFER SHALL be ignored; tx_pop_o, rx_push_o, core_st_o SHALL never assert in IDLE/SETUP/HOLD.
REQ-028 Remaining count SHALL never wrap; decrement only from nonzero.
REQ-029 busy_o SHALL be high in every non-IDLE state.

Reset
REQ-030 rst_i SHALL force IDLE, nss_o all ones, busy_o/done_o/tx_pop_o/rx_push_o/core_st_o 0, counters 0, immediately (async), and mid-transfer with no done_o.

Structure
REQ-031 State enum, CS_WIDTH/LEN_WIDTH/DLY_WIDTH defaults SHALL live in shared package spi_pkg.
REQ-032 One sub-module spi_dly_cnt (loadable down-counter with zero flag) SHALL serve both SETUP and HOLD.

Verification
REQ-033 ass=1, sel=4'b0010, len=3, setup=2, hold=1, TX always valid, RX always ready -> nss_o=4'b1101 for whole transfer, 3 core_st_o, 3 tx_pop_o, 3 rx_push_o, single done_o, first core_st_o 3 cycles after start.
REQ-034 len=2, tx_valid_i low 10 cycles before word 2 -> no core_st_o during gap, nss_o held, completes normally.
REQ-035 len=1, rx_ready_i low 5 cycles at core_done_i -> WAIT_RX, rx_push_o exactly once when ready rises, then HOLD.
REQ-036 en_i dropped during XFER of word 2/4 -> IDLE next cycle, nss_o=4'b1111, no done_o, no further strobes.
REQ-037 start_i with len=0 -> done_o one cycle later, busy_o never high; start_i while busy -> ignored.
REQ-038 rst_i asserted mid-HOLD -> outputs at reset values same edge, no done_o after release.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared widths and state encoding for the SPI transfer sequencer
package spi_pkg;

   localparam int SPI_CS_WIDTH  = 4;
   localparam int SPI_LEN_WIDTH = 16;
   localparam int SPI_DLY_WIDTH = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_WAIT_TX = 3'd2,
      ST_XFER    = 3'd3,
      ST_WAIT_RX = 3'd4,
      ST_HOLD    = 3'd5
   } spi_state_e;

endpackage

// File: rtl/spi_dly_cnt.sv
// rtl/spi_dly_cnt.sv - loadable down-counter with zero flag, shared by setup and hold timing
module spi_dly_cnt
   import spi_pkg::*;
#(
   parameter int WIDTH = SPI_DLY_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt <= '0;
      end else if (clr_i) begin
         cnt <= '0;
      end else if (load_i) begin
         cnt <= load_val_i;
      end else if (dec_i && cnt != '0) begin
         cnt <= cnt - WIDTH'(1);
      end
   end

   assign zero_o = (cnt == '0);

endmodule

// File: rtl/spi_xfer_seq.sv
// rtl/spi_xfer_seq.sv - SPI transfer sequencer: slave select timing, FIFO handshakes, word loop
module spi_xfer_seq
   import spi_pkg::*;
#(
   parameter int CS_WIDTH  = SPI_CS_WIDTH,
   parameter int LEN_WIDTH = SPI_LEN_WIDTH,
   parameter int DLY_WIDTH = SPI_DLY_WIDTH
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic                 start_i,
   input  logic                 ass_i,
   input  logic [CS_WIDTH-1:0]  sel_i,
   input  logic [LEN_WIDTH-1:0] len_i,
   input  logic [DLY_WIDTH-1:0] setup_i,
   input  logic [DLY_WIDTH-1:0] hold_i,
   input  logic                 tx_valid_i,
   output logic                 tx_pop_o,
   input  logic                 rx_ready_i,
   output logic                 rx_push_o,
   output logic                 core_st_o,
   input  logic                 core_done_i,
   output logic [CS_WIDTH-1:0]  nss_o,
   output logic                 busy_o,
   output logic                 done_o
);

   spi_state_e           state;
   logic [CS_WIDTH-1:0]  sel_q;
   logic [LEN_WIDTH-1:0] remain;
   logic [DLY_WIDTH-1:0] hold_q;

   logic                 accept;
   logic                 last_word;
   logic                 active_next;
   spi_state_e           after_push;
   logic                 dly_load;
   logic                 dly_dec;
   logic                 dly_zero;
   logic [DLY_WIDTH-1:0] dly_src;
   logic [DLY_WIDTH-1:0] dly_val;

   // Handshake strobes follow the state register and live inputs so a push lands in the done cycle
   assign core_st_o = en_i && (state == ST_WAIT_TX) && tx_valid_i;
   assign tx_pop_o  = core_st_o;
   assign rx_push_o = en_i && rx_ready_i &&
                      (((state == ST_XFER) && core_done_i) || (state == ST_WAIT_RX));
   assign busy_o    = (state != ST_IDLE);

   assign accept      = en_i && (state == ST_IDLE) && start_i && (len_i != '0);
   assign last_word   = (remain <= LEN_WIDTH'(1));
   assign after_push  = last_word ? ST_HOLD : ST_WAIT_TX;
   assign active_next = accept ||
                        (en_i && (state != ST_IDLE) && !((state == ST_HOLD) && dly_zero));

   // A zero delay still spends one cycle in the state, so load count-1 saturated at zero
   assign dly_src  = (state == ST_IDLE) ? setup_i : hold_q;
   assign dly_val  = (dly_src == '0) ? '0 : dly_src - DLY_WIDTH'(1);
   assign dly_load = accept || (rx_push_o && last_word);
   assign dly_dec  = en_i && ((state == ST_SETUP) || (state == ST_HOLD)) && !dly_zero;

   spi_dly_cnt #(
      .WIDTH(DLY_WIDTH)
   ) u_dly_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (!en_i),
      .load_i     (dly_load),
      .load_val_i (dly_val),
      .dec_i      (dly_dec),
      .zero_o     (dly_zero)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state  <= ST_IDLE;
         sel_q  <= '0;
         remain <= '0;
         hold_q <= '0;
         nss_o  <= '1;
         done_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (!en_i) begin
            state  <= ST_IDLE;
            remain <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start_i) begin
                     if (len_i == '0) begin
                        done_o <= 1'b1;
                     end else begin
                        state  <= ST_SETUP;
                        remain <= len_i;
                        hold_q <= hold_i;
                        sel_q  <= sel_i;
                     end
                  end
               end
               ST_SETUP: begin
                  if (dly_zero) state <= ST_WAIT_TX;
               end
               ST_WAIT_TX: begin
                  if (tx_valid_i) state <= ST_XFER;
               end
               ST_XFER: begin
                  if (core_done_i) state <= rx_ready_i ? after_push : ST_WAIT_RX;
               end
               ST_WAIT_RX: begin
                  if (rx_ready_i) state <= after_push;
               end
               ST_HOLD: begin
                  if (dly_zero) begin
                     state  <= ST_IDLE;
                     done_o <= 1'b1;
                  end
               end
               default: state <= ST_IDLE;
            endcase
            if (rx_push_o && remain != '0) remain <= remain - LEN_WIDTH'(1);
         end

         if (!ass_i) begin
            nss_o <= ~sel_i;
         end else if (active_next) begin
            nss_o <= (state == ST_IDLE) ? ~sel_i : ~sel_q;
         end else begin
            nss_o <= '1;
         end
      end
   end

endmodule

// File: tb/tb_spi_xfer_seq.sv
// tb/tb_spi_xfer_seq.sv - directed vector and corner-sequence bench for spi_xfer_seq
module tb_spi_xfer_seq;

   localparam int CW = 4;
   localparam int LW = 16;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          start = 1'b0;
   logic          ass = 1'b1;
   logic [CW-1:0] sel = '0;
   logic [LW-1:0] len = '0;
   logic [DW-1:0] setup = '0;
   logic [DW-1:0] hold = '0;
   logic          tx_valid = 1'b0;
   logic          rx_ready = 1'b0;
   logic          core_done = 1'b0;
   logic          tx_pop, rx_push, core_st, busy, done;
   logic [CW-1:0] nss;

   spi_xfer_seq #(
      .CS_WIDTH  (CW),
      .LEN_WIDTH (LW),
      .DLY_WIDTH (DW)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .en_i        (en),
      .start_i     (start),
      .ass_i       (ass),
      .sel_i       (sel),
      .len_i       (len),
      .setup_i     (setup),
      .hold_i      (hold),
      .tx_valid_i  (tx_valid),
      .tx_pop_o    (tx_pop),
      .rx_ready_i  (rx_ready),
      .rx_push_o   (rx_push),
      .core_st_o   (core_st),
      .core_done_i (core_done),
      .nss_o       (nss),
      .busy_o      (busy),
      .done_o      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          start;
      logic          core_done;
      logic          ass;
      logic [CW-1:0] sel;
      logic [CW-1:0] nss;
      logic          busy;
      logic          done;
      logic          pop;
      logic          push;
      logic          st;
   } vec_t;

   int n_pass = 0;
   int n_checks = 0;
   int n_st, n_pop, n_push, n_done;
   logic busy_seen;
   logic gap_bad;
   logic [CW-1:0] s_nss;
   logic s_busy, s_done, s_pop, s_push, s_st;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic clear_counts();
      n_st = 0; n_pop = 0; n_push = 0; n_done = 0; busy_seen = 1'b0;
   endtask

   // Sample mid-cycle, tally strobes, then advance to just after the next rising edge
   task automatic cycle();
      @(negedge clk);
      s_nss = nss; s_busy = busy; s_done = done;
      s_pop = tx_pop; s_push = rx_push; s_st = core_st;
      n_st += int'(s_st); n_pop += int'(s_pop); n_push += int'(s_push); n_done += int'(s_done);
      if (s_busy) busy_seen = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int limit, input string name);
      int k = 0;
      while (!s_done && k < limit) begin
         cycle();
         k++;
      end
      check(name, {31'd0, s_done}, 32'd1);
   endtask

   function automatic vec_t v(input logic st_in, input logic cd, input logic a, input logic [CW-1:0] sl,
                              input logic [CW-1:0] e_nss, input logic e_busy, input logic e_done,
                              input logic e_pop, input logic e_push, input logic e_st);
      vec_t r;
      r.start = st_in; r.core_done = cd; r.ass = a; r.sel = sl;
      r.nss = e_nss; r.busy = e_busy; r.done = e_done; r.pop = e_pop; r.push = e_push; r.st = e_st;
      return r;
   endfunction

   vec_t tbl[16];

   initial begin
      // len=3 setup=2 hold=1, slave 1 in auto mode; core_done also poked in SETUP and HOLD
      tbl[0]  = v(1'b1, 1'b0, 1'b1, 4'b0010, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[1]  = v(1'b0, 1'b1, 1'b1, 4'b0010, 4'b1101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[2]  = v(1'b0, 1'b0, 1'b1, 4'b0010, 4'b1101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[3]  = v(1'b0, 1'b0, 1'b1, 4'b0010, 4'b1101, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      tbl[4]  = v(1'b0, 1'b0, 1'b1, 4'b0010, 4'b1101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[5]  = v(1'b0, 1'b1, 1'b1, 4'b0010, 4'b1101, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      tbl[6]  = v(1'b0, 1'b0, 1'b1, 4'b0010, 4'b1101, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      tbl[7]  = v(1'b0, 1'b1, 1'b1, 4'b0010, 4'b1101, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      tbl[8]  = v(1'b0, 1'b0, 1'b1, 4'b0010, 4'b1101, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      tbl[9]  = v(1'b0, 1'b1, 1'b1, 4'b0010, 4'b1101, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      tbl[10] = v(1'b0, 1'b1, 1'b1, 4'b0010, 4'b1101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[11] = v(1'b0, 1'b0, 1'b1, 4'b0010, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tbl[12] = v(1'b0, 1'b0, 1'b0, 4'b0110, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[13] = v(1'b0, 1'b0, 1'b0, 4'b0110, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[14] = v(1'b0, 1'b0, 1'b1, 4'b0110, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tbl[15] = v(1'b0, 1'b0, 1'b1, 4'b0110, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      tx_valid = 1'b1; rx_ready = 1'b1;
      @(negedge clk);
      check("reset_outputs", {26'd0, nss, busy, done, tx_pop, rx_push, core_st}, {26'd0, 4'b1111, 5'b00000});
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0; en = 1'b1;

      len = 16'd3; setup = 8'd2; hold = 8'd1;
      clear_counts();
      for (int i = 0; i < 16; i++) begin
         start = tbl[i].start; core_done = tbl[i].core_done; ass = tbl[i].ass; sel = tbl[i].sel;
         cycle();
         check($sformatf("vec%0d", i), {26'd0, s_nss, s_busy, s_done, s_pop, s_push, s_st},
               {26'd0, tbl[i].nss, tbl[i].busy, tbl[i].done, tbl[i].pop, tbl[i].push, tbl[i].st});
      end
      check("vec_push_count", n_push, 32'd3);
      check("vec_done_count", n_done, 32'd1);
      start = 1'b0; core_done = 1'b0; ass = 1'b1;

      // TX underrun gap before word 2
      sel = 4'b0100; len = 16'd2; setup = 8'd0; hold = 8'd0;
      clear_counts();
      start = 1'b1; cycle(); start = 1'b0;
      cycle();
      cycle(); check("gap_first_st", {31'd0, s_st}, 32'd1);
      core_done = 1'b1; cycle(); core_done = 1'b0;
      tx_valid = 1'b0; gap_bad = 1'b0;
      repeat (10) begin
         cycle();
         if (s_st || s_pop || s_nss != 4'b1011 || !s_busy) gap_bad = 1'b1;
      end
      check("gap_quiet", {31'd0, gap_bad}, 32'd0);
      tx_valid = 1'b1; cycle(); check("gap_second_st", {31'd0, s_st}, 32'd1);
      core_done = 1'b1; cycle(); core_done = 1'b0;
      wait_done(10, "gap_done");
      check("gap_st_count", n_st, 32'd2);
      check("gap_push_count", n_push, 32'd2);

      // RX back-pressure at word completion
      sel = 4'b1000; len = 16'd1; rx_ready = 1'b0;
      clear_counts();
      start = 1'b1; cycle(); start = 1'b0;
      cycle();
      cycle();
      core_done = 1'b1; cycle(); core_done = 1'b0;
      check("rx_no_push_at_done", {31'd0, s_push}, 32'd0);
      repeat (4) cycle();
      check("rx_wait_no_push", n_push, 32'd0);
      check("rx_wait_busy", {31'd0, s_busy}, 32'd1);
      rx_ready = 1'b1; cycle();
      check("rx_push_on_ready", {31'd0, s_push}, 32'd1);
      wait_done(5, "rx_done");
      check("rx_push_count", n_push, 32'd1);

      // Enable dropped during word 2 of 4
      sel = 4'b0001; len = 16'd4;
      clear_counts();
      start = 1'b1; cycle(); start = 1'b0;
      cycle();
      cycle();
      core_done = 1'b1; cycle(); core_done = 1'b0;
      cycle();
      en = 1'b0; core_done = 1'b1; cycle();
      check("abort_no_strobe", {29'd0, s_st, s_pop, s_push}, 32'd0);
      en = 1'b1; core_done = 1'b0;
      cycle();
      check("abort_idle", {27'd0, s_nss, s_busy}, {27'd0, 4'b1111, 1'b0});
      clear_counts();
      repeat (6) cycle();
      check("abort_quiet", n_st + n_pop + n_push + n_done + int'(busy_seen), 32'd0);

      // Zero-length start, then a start while busy
      clear_counts();
      len = 16'd0; start = 1'b1; cycle(); start = 1'b0;
      cycle();
      check("zero_len_done", {31'd0, s_done}, 32'd1);
      check("zero_len_never_busy", {31'd0, busy_seen}, 32'd0);
      clear_counts();
      len = 16'd2; setup = 8'd3; sel = 4'b0010; core_done = 1'b1;
      start = 1'b1; cycle(); start = 1'b0;
      cycle();
      len = 16'd1; sel = 4'b1000; start = 1'b1; cycle(); start = 1'b0;
      check("busy_start_nss", {28'd0, s_nss}, {28'd0, 4'b1101});
      wait_done(20, "busy_start_done");
      check("busy_start_push_count", n_push, 32'd2);
      core_done = 1'b0;

      // Reset asserted in the middle of HOLD
      cycle();
      len = 16'd1; setup = 8'd0; hold = 8'd5; sel = 4'b0100; core_done = 1'b1;
      start = 1'b1; cycle(); start = 1'b0;
      cycle();
      cycle();
      cycle();
      cycle();
      cycle();
      check("hold_busy", {27'd0, s_nss, s_busy}, {27'd0, 4'b1011, 1'b1});
      rst = 1'b1; core_done = 1'b0;
      #1;
      check("hold_reset_async", {26'd0, nss, busy, done, tx_pop, rx_push, core_st}, {26'd0, 4'b1111, 5'b00000});
      @(posedge clk); #1;
      rst = 1'b0;
      clear_counts();
      repeat (10) cycle();
      check("hold_reset_no_done", n_done + int'(busy_seen), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
